// File: rtl/clock_gen.sv
// clock_gen: divides fpga_clk into clk, phi_0 and a delayed copy phi_2.
// Define CLOCK_GEN_STROBE_EN to add the phi2_rise / phi2_fall strobes.
module clock_gen #(
  parameter int CLK_DIV  = 2,
  parameter int PHI_DIV  = 50,
  parameter int PHI2_DLY = 2
) (
  input  logic fpga_clk,
  input  logic rst_n,
  output logic clk,
  output logic phi_0,
`ifdef CLOCK_GEN_STROBE_EN
  output logic phi_2,
  output logic phi2_rise,
  output logic phi2_fall
`else
  output logic phi_2
`endif
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = $clog2(PHI_DIV);
  localparam int PLOW = (PHI_DIV + 1) / 2;

  localparam logic [CW-1:0] C_TOP = CW'(HALF - 1);
  localparam logic [PW-1:0] P_TOP = PW'(PHI_DIV - 1);
  localparam logic [PW-1:0] P_LOW = PW'(PLOW);

  logic [1:0]    sync_q;
  logic          run;
  logic [CW-1:0] c_cnt;
  logic [CW-1:0] c_nxt;
  logic [PW-1:0] p_cnt;
  logic [PW-1:0] p_nxt;
  logic          clk_nxt;
  logic          phi0_nxt;
`ifdef CLOCK_GEN_STROBE_EN
  logic          phi2_nxt;
`endif

  // Two-flop release synchroniser; counting starts on the second edge.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = |sync_q;

  // Next counter and clock values; phi_0 high in upper part of period.
  always_comb begin
    c_nxt   = c_cnt;
    p_nxt   = p_cnt;
    clk_nxt = clk;
    if (run) begin
      if (c_cnt == C_TOP) begin
        c_nxt   = '0;
        clk_nxt = ~clk;
      end else begin
        c_nxt = c_cnt + CW'(1);
      end
      if (p_cnt == P_TOP) begin
        p_nxt = '0;
      end else begin
        p_nxt = p_cnt + PW'(1);
      end
    end
    phi0_nxt = (p_nxt >= P_LOW);
  end

  // Counter and output registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= '0;
      p_cnt <= '0;
      clk   <= 1'b0;
      phi_0 <= 1'b0;
    end else begin
      c_cnt <= c_nxt;
      p_cnt <= p_nxt;
      clk   <= clk_nxt;
      phi_0 <= phi0_nxt;
    end
  end

  if (PHI2_DLY == 0) begin : g_nodly
    assign phi_2 = phi_0;
`ifdef CLOCK_GEN_STROBE_EN
    assign phi2_nxt = phi0_nxt;
`endif
  end else begin : g_dly
    logic [PHI2_DLY-1:0] dly;
    logic [PHI2_DLY-1:0] dly_nxt;

    // Shift phi_0 in at the bottom of the chain.
    always_comb begin
      dly_nxt    = dly << 1;
      dly_nxt[0] = phi_0;
    end

    // Delay chain registers; top stage is phi_2.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
        dly <= '0;
      end else begin
        dly <= dly_nxt;
      end
    end

    assign phi_2 = dly[PHI2_DLY-1];
`ifdef CLOCK_GEN_STROBE_EN
    assign phi2_nxt = dly_nxt[PHI2_DLY-1];
`endif
  end

`ifdef CLOCK_GEN_STROBE_EN
  // Edge strobes registered alongside phi_2 so they line up with it.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_rise <= 1'b0;
      phi2_fall <= 1'b0;
    end else begin
      phi2_rise <= phi2_nxt & ~phi_2;
      phi2_fall <= ~phi2_nxt & phi_2;
    end
  end
`endif

endmodule

// File: tb/tb_clock_gen.sv
// tb_clock_gen: three clock_gen configurations under random reset pulses,
// compared each cycle against an edge-count reference model.
module tb_clock_gen;

  typedef struct packed {
    logic c;
    logic p0;
    logic p2;
    logic r;
    logic f;
  } e_t;
  typedef e_t [2:0] ev_t;

  int hv[3] = '{1, 2, 3};
  int pv[3] = '{50, 5, 7};
  int dv[3] = '{2, 0, 1};

  logic fpga_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] a_clk;
  logic [2:0] a_p0;
  logic [2:0] a_p2;
  logic [2:0] a_r;
  logic [2:0] a_f;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  seen = 0;
  int  n = 0;
  logic prev2[3] = '{1'b0, 1'b0, 1'b0};

  always #10 fpga_clk = ~fpga_clk;

`ifdef CLOCK_GEN_STROBE_EN
  clock_gen u_a (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[0]), .phi_0(a_p0[0]), .phi_2(a_p2[0]),
    .phi2_rise(a_r[0]), .phi2_fall(a_f[0]));
  clock_gen #(.CLK_DIV(4), .PHI_DIV(5), .PHI2_DLY(0)) u_b (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[1]), .phi_0(a_p0[1]), .phi_2(a_p2[1]),
    .phi2_rise(a_r[1]), .phi2_fall(a_f[1]));
  clock_gen #(.CLK_DIV(6), .PHI_DIV(7), .PHI2_DLY(1)) u_c (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[2]), .phi_0(a_p0[2]), .phi_2(a_p2[2]),
    .phi2_rise(a_r[2]), .phi2_fall(a_f[2]));
`else
  assign a_r = '0;
  assign a_f = '0;
  clock_gen u_a (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[0]), .phi_0(a_p0[0]), .phi_2(a_p2[0]));
  clock_gen #(.CLK_DIV(4), .PHI_DIV(5), .PHI2_DLY(0)) u_b (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[1]), .phi_0(a_p0[1]), .phi_2(a_p2[1]));
  clock_gen #(.CLK_DIV(6), .PHI_DIV(7), .PHI2_DLY(1)) u_c (
    .fpga_clk(fpga_clk), .rst_n(rst_n),
    .clk(a_clk[2]), .phi_0(a_p0[2]), .phi_2(a_p2[2]));
`endif

  // phi_0 after counted edge m: low for ceil(p/2) edges, then high.
  function automatic logic ph(input int m, input int p);
    return (m > 0) && ((m % p) >= (p + 1) / 2);
  endfunction

  task automatic push_exp();
    ev_t  e;
    logic p2;
    for (int i = 0; i < 3; i++) begin
      p2 = ph(n - dv[i], pv[i]);
      e[i].c  = ((n / hv[i]) % 2) == 1;
      e[i].p0 = ph(n, pv[i]);
      e[i].p2 = p2;
      e[i].r  = p2 & ~prev2[i];
      e[i].f  = ~p2 & prev2[i];
      prev2[i] = p2;
    end
    q.push_back(e);
  endtask

  task automatic step(input logic r);
    @(posedge fpga_clk);
    if (!rst_n) begin
      seen = 0;
      n = 0;
    end else begin
      if (seen < 2) seen++;
      if (seen >= 2) n++;
    end
    #5;
    rst_n = r;
    if (!r) begin
      seen = 0;
      n = 0;
      for (int i = 0; i < 3; i++) prev2[i] = 1'b0;
    end
    push_exp();
  endtask

  task automatic chk(input string nm, input int i,
                     input logic a, input logic x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%b exp=%b", nm, i, $time, a, x);
    end
  endtask

  // Monitor: pop one expectation per cycle, compare on the falling edge.
  always @(negedge fpga_clk) begin
    ev_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("clk", i, a_clk[i], e[i].c);
        chk("phi_0", i, a_p0[i], e[i].p0);
        chk("phi_2", i, a_p2[i], e[i].p2);
`ifdef CLOCK_GEN_STROBE_EN
        chk("phi2_rise", i, a_r[i], e[i].r);
        chk("phi2_fall", i, a_f[i], e[i].f);
`endif
      end
    end
  end

  initial begin
    repeat (4) step(1'b0);
    for (int k = 0; k < 200 && n != 37; k++) step(1'b1);
    total++;
    if (n != 37) begin
      bad++;
      $display("FAIL reach_edge37 got=%0d exp=37", n);
    end
    repeat (3) step(1'b0);
    repeat (130) step(1'b1);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(160, 1)) step(1'b1);
      repeat ($urandom_range(4, 1)) step(1'b0);
    end
    repeat (560) step(1'b1);
    @(negedge fpga_clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
